// File: rtl/fetch_queue_if.sv
// Fetch-queue port bundle: icache request/response, redirect, decode handshake, occupancy.
// master = fetch_queue side, slave = surrounding pipeline/icache side.
interface fetch_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  icache_req_valid_o;
    logic [ADDR_WIDTH-1:0] icache_req_addr_o;
    logic                  icache_req_ready_i;
    logic                  icache_rsp_valid_i;
    logic [31:0]           icache_rsp_data_i;
    logic                  redirect_valid_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  instr_valid_o;
    logic [31:0]           instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic                  instr_ready_i;
    logic [CW-1:0]         count_o;
    logic                  empty_o;
    logic                  full_o;

    modport master (
        output icache_req_valid_o, icache_req_addr_o,
        input  icache_req_ready_i, icache_rsp_valid_i, icache_rsp_data_i,
        input  redirect_valid_i, redirect_pc_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i,
        output count_o, empty_o, full_o
    );

    modport slave (
        input  icache_req_valid_o, icache_req_addr_o,
        output icache_req_ready_i, icache_rsp_valid_i, icache_rsp_data_i,
        output redirect_valid_i, redirect_pc_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i,
        input  count_o, empty_o, full_o
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: issues sequential icache fetches, buffers {instr, pc}, flushes on redirect.
// Hit latency 1 cycle to decode; issue stalls when queued + in-flight reaches DEPTH, so nothing is ever dropped.
module fetch_queue #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_queue_if.master fq
);
    localparam int                    CW      = $clog2(DEPTH + 1);
    localparam int                    PW      = $clog2(DEPTH);
    localparam logic [CW:0]           DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [PW-1:0]         head_r, tail_r;
    logic [CW-1:0]         count_r, inflight_r, discard_r;
    logic [ADDR_WIDTH-1:0] fetch_pc_r, rsp_pc_r;

    logic                  accept, rsp_ok, push, pop, drop, redirect;
    logic [CW:0]           occupancy;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  unused_redirect_lsbs;

    assign redirect    = fq.redirect_valid_i;
    assign redirect_pc = {fq.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^fq.redirect_pc_i[1:0];

    // Issue capacity only counts registered state; a same-cycle pop frees a slot next cycle.
    assign occupancy             = {1'b0, count_r} + {1'b0, inflight_r};
    assign fq.icache_req_valid_o = rst_ni && !redirect && (occupancy < DEPTH_W);
    assign fq.icache_req_addr_o  = fetch_pc_r;
    assign accept                = fq.icache_req_valid_o && fq.icache_req_ready_i;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok = fq.icache_rsp_valid_i && ((inflight_r != '0) || accept);
    assign drop   = rsp_ok && (discard_r != '0);
    assign push   = rsp_ok && (discard_r == '0) && !redirect;
    assign pop    = fq.instr_valid_o && fq.instr_ready_i && !redirect;

    assign fq.instr_valid_o = (count_r != '0);
    assign fq.instr_o       = fq.instr_valid_o ? mem[head_r].instr : '0;
    assign fq.instr_pc_o    = fq.instr_valid_o ? mem[head_r].pc : '0;
    assign fq.count_o       = count_r;
    assign fq.empty_o       = (count_r == '0);
    assign fq.full_o        = (count_r == CW'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            inflight_r <= '0;
            discard_r  <= '0;
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
        end else begin
            inflight_r <= inflight_r + CW'(accept) - CW'(rsp_ok);
            if (redirect) begin
                head_r     <= '0;
                tail_r     <= '0;
                count_r    <= '0;
                fetch_pc_r <= redirect_pc;
                rsp_pc_r   <= redirect_pc;
                // inflight_r already covers responses still being discarded, so every
                // outstanding response after this cycle belongs to a squashed stream.
                discard_r  <= inflight_r - CW'(rsp_ok);
            end else begin
                if (accept) fetch_pc_r <= fetch_pc_r + PC_STEP;
                if (drop)   discard_r  <= discard_r - CW'(1);
                if (push) begin
                    tail_r   <= tail_r + PW'(1);
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                end
                if (pop) head_r <= head_r + PW'(1);
                count_r <= count_r + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) mem[tail_r] <= '{instr: fq.icache_rsp_data_i, pc: rsp_pc_r};
    end

    rsp_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fq.icache_rsp_valid_i |-> ((inflight_r != '0) || accept));

    push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (count_r == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: icache model with per-request latency plus a scoreboard of expected {pc, instr}.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          AW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) fq ();
    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .fq    (fq)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          sq;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    req_t        pq[$];
    exp_t        exp_q[$];
    logic [31:0] seen[$];
    int          tests = 0, fails = 0, cyc = 0;
    int          hit_lat = 0, miss_lat = 0, n_acc = 0, first_cyc = -1, mark = 0;
    logic [31:0] miss_addr = 32'h1, exp_fetch = RESET_PC;
    bit          rdy = 1'b1, c_rdy = 1'b1, redir = 1'b0;
    logic [31:0] redir_pc = '0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step();
        req_t r;
        bit   got;
        bit   popped;
        exp_t e;
        fq.redirect_valid_i   = redir;
        fq.redirect_pc_i      = redir_pc;
        fq.instr_ready_i      = rdy;
        fq.icache_req_ready_i = c_rdy;
        fq.icache_rsp_valid_i = 1'b0;
        fq.icache_rsp_data_i  = '0;
        #1;
        chk("count", 32'(fq.count_o), 32'(exp_q.size()));
        chk("empty", 32'(fq.empty_o), 32'(exp_q.size() == 0));
        chk("full", 32'(fq.full_o), 32'(exp_q.size() == DEPTH));
        chk("instr_valid", 32'(fq.instr_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("head_pc", fq.instr_pc_o, exp_q[0].pc);
            chk("head_data", fq.instr_o, exp_q[0].data);
        end
        chk("req_valid", 32'(fq.icache_req_valid_o), 32'(!redir && (exp_q.size() + pq.size() < DEPTH)));
        if (fq.icache_req_valid_o) chk("req_addr", fq.icache_req_addr_o, exp_fetch);
        if (fq.icache_req_valid_o && c_rdy) begin
            r.addr = exp_fetch;
            r.due  = cyc + ((exp_fetch == miss_addr) ? miss_lat : hit_lat);
            r.sq   = 1'b0;
            pq.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
            n_acc++;
        end
        got = 1'b0;
        if (pq.size() != 0 && pq[0].due <= cyc) begin
            r   = pq.pop_front();
            got = 1'b1;
            fq.icache_rsp_valid_i = 1'b1;
            fq.icache_rsp_data_i  = data_of(r.addr);
        end
        popped = fq.instr_valid_o && rdy;
        if (redir) begin
            foreach (pq[i]) pq[i].sq = 1'b1;
            exp_q.delete();
            exp_fetch = redir_pc & ~32'h3;
        end else begin
            if (popped && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (seen.size() == 0) first_cyc = cyc;
                seen.push_back(e.pc);
            end
            if (got && !r.sq) exp_q.push_back('{pc: r.addr, data: data_of(r.addr)});
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        rst_n                 = 1'b0;
        fq.redirect_valid_i   = 1'b0;
        fq.redirect_pc_i      = '0;
        fq.instr_ready_i      = 1'b1;
        fq.icache_req_ready_i = 1'b1;
        fq.icache_rsp_valid_i = 1'b0;
        fq.icache_rsp_data_i  = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_req_valid", 32'(fq.icache_req_valid_o), 32'd0);
        chk("rst_req_addr", fq.icache_req_addr_o, RESET_PC);
        chk("rst_instr_valid", 32'(fq.instr_valid_o), 32'd0);
        chk("rst_instr", fq.instr_o, 32'd0);
        chk("rst_instr_pc", fq.instr_pc_o, 32'd0);
        chk("rst_count", 32'(fq.count_o), 32'd0);
        chk("rst_full", 32'(fq.full_o), 32'd0);
        chk("rst_empty", 32'(fq.empty_o), 32'd1);
        rst_n = 1'b1;

        // Always-hit, always-ready streaming from RESET_PC.
        seen.delete();
        repeat (12) step();
        chk("t1_delivered", 32'(seen.size()), 32'd11);
        chk("t1_first_pc", seen[0], 32'h100);
        chk("t1_first_cyc", 32'(first_cyc), 32'd1);
        chk("t1_last_pc", seen[10], 32'h128);

        // Decode backpressure from an empty queue.
        c_rdy = 1'b0;
        repeat (3) step();
        rdy   = 1'b0;
        c_rdy = 1'b1;
        n_acc = 0;
        repeat (8) step();
        chk("t2_accepts", 32'(n_acc), 32'd4);
        chk("t2_count", 32'(fq.count_o), 32'd4);
        chk("t2_full", 32'(fq.full_o), 32'd1);
        rdy = 1'b1;
        seen.delete();
        repeat (8) step();
        chk("t2_delivered", 32'(seen.size()), 32'd8);
        chk("t2_first_pc", seen[0], 32'h130);
        chk("t2_fourth_pc", seen[3], 32'h13C);

        // 10-cycle miss on the first fetch after a redirect to 0x200.
        miss_addr = 32'h200;
        miss_lat  = 10;
        redir     = 1'b1;
        redir_pc  = 32'h200;
        mark      = cyc;
        step();
        redir = 1'b0;
        seen.delete();
        repeat (16) step();
        chk("t3_first_pc", seen[0], 32'h200);
        chk("t3_first_cyc", 32'(first_cyc), 32'(mark + 12));
        chk("t3_second_pc", seen[1], 32'h204);
        miss_addr = 32'h1;

        // Redirect with 2 queued and 2 in flight; the late responses must be dropped.
        redir    = 1'b1;
        redir_pc = 32'h600;
        rdy      = 1'b0;
        hit_lat  = 0;
        step();
        redir = 1'b0;
        repeat (2) step();
        hit_lat = 6;
        repeat (2) step();
        redir    = 1'b1;
        redir_pc = 32'h403;
        rdy      = 1'b1;
        hit_lat  = 0;
        step();
        chk("t4_count_after", 32'(fq.count_o), 32'd0);
        chk("t4_valid_after", 32'(fq.instr_valid_o), 32'd0);
        chk("t4_discard", 32'(dut.discard_r), 32'd2);
        redir = 1'b0;
        seen.delete();
        repeat (15) step();
        chk("t4_first_pc", seen[0], 32'h400);
        chk("t4_second_pc", seen[1], 32'h404);

        // Redirect in the same cycle as a pop and an old-stream response.
        redir    = 1'b1;
        redir_pc = 32'h700;
        rdy      = 1'b0;
        step();
        redir = 1'b0;
        step();
        hit_lat = 2;
        repeat (2) step();
        redir    = 1'b1;
        redir_pc = 32'h800;
        rdy      = 1'b1;
        hit_lat  = 0;
        step();
        chk("t5_count_after", 32'(fq.count_o), 32'd0);
        chk("t5_discard", 32'(dut.discard_r), 32'd1);
        redir = 1'b0;
        seen.delete();
        repeat (8) step();
        chk("t5_first_pc", seen[0], 32'h800);

        // Address wrap at the top of the address space.
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFF8;
        step();
        redir = 1'b0;
        seen.delete();
        repeat (8) step();
        chk("t6_delivered_ge4", 32'(seen.size() >= 4), 32'd1);
        chk("t6_pc0", seen[0], 32'hFFFF_FFF8);
        chk("t6_pc1", seen[1], 32'hFFFF_FFFC);
        chk("t6_pc2", seen[2], 32'h0000_0000);
        chk("t6_pc3", seen[3], 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
